// File: rtl/fu_sched_pkg.sv
// fu_sched_pkg: shared state encoding and FU class constants for the issue scheduler
package fu_sched_pkg;
   localparam logic FU_ALU = 1'b0;
   localparam logic FU_MEM = 1'b1;
   typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_DONE} fu_sched_mem_state_e;
endpackage

// File: rtl/fu_issue_scheduler_rr_picker.sv
// rr_picker: combinational find-first-set over a row vector, scanning circularly from start_i
module rr_picker #(
   parameter int NUM_RS_ROWS = 16,
   localparam int IW = $clog2(NUM_RS_ROWS)
) (
   input  logic [NUM_RS_ROWS-1:0] req_i,
   input  logic [IW-1:0]          start_i,
   output logic                   valid_o,
   output logic [IW-1:0]          idx_o
);
   // Scan from the far end back toward start so the closest set row is written last.
   always_comb begin
      valid_o = 1'b0;
      idx_o = '0;
      for (int i = NUM_RS_ROWS - 1; i >= 0; i--) begin
         if (req_i[start_i + IW'(i)]) begin
            valid_o = 1'b1;
            idx_o = start_i + IW'(i);
         end
      end
   end
endmodule

// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler: picks ready ALU/memory rows each cycle and sequences the multi-cycle memory FU.
// Define FU_SCHED_ROUND_ROBIN_EN for circular scan from rotating pointers; otherwise lowest row wins.
module fu_issue_scheduler
   import fu_sched_pkg::*;
#(
   parameter int NUM_RS_ROWS = 16,
   parameter int NUM_ALU_FUS = 2,
   parameter int MEM_LATENCY = 2,
   localparam int IW = $clog2(NUM_RS_ROWS)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic [NUM_RS_ROWS-1:0]     ready_vec_i,
   input  logic [NUM_RS_ROWS-1:0]     is_mem_vec_i,
   output logic [NUM_ALU_FUS-1:0]     alu_grant_valid_o,
   output logic [NUM_ALU_FUS*IW-1:0]  alu_grant_row_o,
   output logic                       mem_grant_valid_o,
   output logic [IW-1:0]              mem_grant_row_o,
   output logic                       mem_done_o,
   output logic                       mem_busy_o
);
   localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

   fu_sched_mem_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [NUM_RS_ROWS-1:0] gmask_q, gmask_d, mem_req;
   logic [NUM_ALU_FUS-1:0][NUM_RS_ROWS-1:0] alu_req;
   logic [NUM_ALU_FUS-1:0] alu_v, alu_gv_d, alu_gv_q;
   logic [NUM_ALU_FUS-1:0][IW-1:0] alu_idx, alu_row_d, alu_row_q;
   logic mem_v, mem_sel, mem_gv_q, mem_done_d, mem_done_q;
   logic [IW-1:0] mem_idx, mem_row_d, mem_row_q, alu_start, mem_start;

   assign alu_req[0] = ready_vec_i & ~is_mem_vec_i & ~gmask_q;
   assign mem_req = ready_vec_i & is_mem_vec_i & ~gmask_q;

   genvar k;
   generate
      for (k = 0; k < NUM_ALU_FUS; k++) begin : g_alu
         if (k > 0) begin : g_mask
            assign alu_req[k] = alu_req[k-1] & ~(NUM_RS_ROWS'(alu_v[k-1]) << alu_idx[k-1]);
         end
         rr_picker #(.NUM_RS_ROWS(NUM_RS_ROWS)) u_pick (
            .req_i(alu_req[k]), .start_i(alu_start), .valid_o(alu_v[k]), .idx_o(alu_idx[k]));
      end
   endgenerate

   rr_picker #(.NUM_RS_ROWS(NUM_RS_ROWS)) u_mem_pick (
      .req_i(mem_req), .start_i(mem_start), .valid_o(mem_v), .idx_o(mem_idx));

`ifdef FU_SCHED_ROUND_ROBIN_EN
   logic [IW-1:0] alu_ptr_q, alu_ptr_d, mem_ptr_q, mem_ptr_d;
   assign alu_start = alu_ptr_q;
   assign mem_start = mem_ptr_q;
   // Advance each pointer just past the last row it granted; grants are already flush-gated.
   always_comb begin
      alu_ptr_d = alu_ptr_q;
      for (int i = 0; i < NUM_ALU_FUS; i++) if (alu_gv_d[i]) alu_ptr_d = alu_row_d[i] + IW'(1);
      mem_ptr_d = mem_sel ? mem_idx + IW'(1) : mem_ptr_q;
   end
   // Pointers survive flush so squashes do not reset fairness.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         alu_ptr_q <= '0;
         mem_ptr_q <= '0;
      end else begin
         alu_ptr_q <= alu_ptr_d;
         mem_ptr_q <= mem_ptr_d;
      end
   end
`else
   assign alu_start = '0;
   assign mem_start = '0;
`endif

   // Gate picks with flush and FU availability, and collect this edge's grants into the next mask.
   always_comb begin
      gmask_d = '0;
      alu_gv_d = '0;
      alu_row_d = '0;
      for (int i = 0; i < NUM_ALU_FUS; i++) begin
         alu_gv_d[i] = alu_v[i] & ~flush_i;
         alu_row_d[i] = alu_gv_d[i] ? alu_idx[i] : '0;
         if (alu_gv_d[i]) gmask_d[alu_idx[i]] = 1'b1;
      end
      mem_sel = mem_v & ~flush_i & (state_q != MEM_BUSY);
      mem_row_d = mem_sel ? mem_idx : '0;
      if (mem_sel) gmask_d[mem_idx] = 1'b1;
   end

   // Memory FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= MEM_IDLE;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
      end
   end

   // Memory FSM next state: a new grant reloads the latency counter from IDLE or DONE.
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         state_d = MEM_IDLE;
      end else if (mem_sel) begin
         cnt_d = CNT_LOAD;
         state_d = (CNT_LOAD == 4'd0) ? MEM_DONE : MEM_BUSY;
      end else if (state_q == MEM_BUSY) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) state_d = MEM_DONE;
      end else if (state_q == MEM_DONE) begin
         state_d = MEM_IDLE;
      end
   end

   // Memory FSM outputs; the done pulse is registered one cycle after DONE and killed by flush.
   always_comb begin
      mem_busy_o = (state_q == MEM_BUSY);
      mem_done_d = (state_q == MEM_DONE) & ~flush_i;
   end

   // Grant, done and mask registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         alu_gv_q <= '0;
         alu_row_q <= '0;
         mem_gv_q <= 1'b0;
         mem_row_q <= '0;
         mem_done_q <= 1'b0;
         gmask_q <= '0;
      end else begin
         alu_gv_q <= alu_gv_d;
         alu_row_q <= alu_row_d;
         mem_gv_q <= mem_sel;
         mem_row_q <= mem_row_d;
         mem_done_q <= mem_done_d;
         gmask_q <= gmask_d;
      end
   end

   assign alu_grant_valid_o = alu_gv_q;
   assign alu_grant_row_o = alu_row_q;
   assign mem_grant_valid_o = mem_gv_q;
   assign mem_grant_row_o = mem_row_q;
   assign mem_done_o = mem_done_q;
endmodule

// File: tb/tb_fu_issue_scheduler.sv
// tb_fu_issue_scheduler: scoreboard bench driving MEM_LATENCY=2 and MEM_LATENCY=1 instances in lockstep
module tb_fu_issue_scheduler;
`ifdef FU_SCHED_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct packed {
      logic [1:0] av;
      logic [7:0] ar;
      logic       mv;
      logic [3:0] mr;
      logic       done;
      logic       busy;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic [15:0] rdy = '0, ism = '0;
   logic [1:0] av0, av1;
   logic [7:0] ar0, ar1;
   logic mv0, mv1, dn0, dn1, bz0, bz1;
   logic [3:0] mr0, mr1;
   exp_t q0[$], q1[$];
   logic [15:0] mg[2];
   int aptr[2], mptr[2], rem[2];
   int n_chk = 0, n_bad = 0;
   logic [5:0] d0v, d1v, b1v;

   always #5 clk = ~clk;

   fu_issue_scheduler #(.NUM_RS_ROWS(16), .NUM_ALU_FUS(2), .MEM_LATENCY(2)) u_l2 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .ready_vec_i(rdy), .is_mem_vec_i(ism),
      .alu_grant_valid_o(av0), .alu_grant_row_o(ar0), .mem_grant_valid_o(mv0),
      .mem_grant_row_o(mr0), .mem_done_o(dn0), .mem_busy_o(bz0));

   fu_issue_scheduler #(.NUM_RS_ROWS(16), .NUM_ALU_FUS(2), .MEM_LATENCY(1)) u_l1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .ready_vec_i(rdy), .is_mem_vec_i(ism),
      .alu_grant_valid_o(av1), .alu_grant_row_o(ar1), .mem_grant_valid_o(mv1),
      .mem_grant_row_o(mr1), .mem_done_o(dn1), .mem_busy_o(bz1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [15:0] req, input int start);
      for (int i = 0; i < 16; i++) if (req[(start + i) % 16]) return (start + i) % 16;
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mg[d] = '0;
         aptr[d] = 0;
         mptr[d] = 0;
         rem[d] = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic cmp(input int d, input exp_t e);
      chk($sformatf("d%0d_alu_v", d), d ? av1 : av0, e.av);
      chk($sformatf("d%0d_alu_row", d), d ? ar1 : ar0, e.ar);
      chk($sformatf("d%0d_mem_v", d), d ? mv1 : mv0, e.mv);
      chk($sformatf("d%0d_mem_row", d), d ? mr1 : mr0, e.mr);
      chk($sformatf("d%0d_mem_done", d), d ? dn1 : dn0, e.done);
      chk($sformatf("d%0d_mem_busy", d), d ? bz1 : bz0, e.busy);
   endtask

   // rem[d]: cycles from the current cycle until the pending done pulse (0 = nothing pending)
   task automatic step(input logic [15:0] r_i, input logic [15:0] m_i, input logic f_i);
      rdy = r_i;
      ism = m_i;
      flush = f_i;
      for (int d = 0; d < 2; d++) begin
         exp_t e;
         logic [15:0] ae, me, ng;
         int r, as;
         e = '0;
         ng = '0;
         ae = r_i & ~m_i & ~mg[d];
         me = r_i & m_i & ~mg[d];
         as = RR ? aptr[d] : 0;
         if (!f_i) begin
            for (int k = 0; k < 2; k++) begin
               r = pick(ae, as);
               if (r >= 0) begin
                  e.av[k] = 1'b1;
                  e.ar[k*4 +: 4] = 4'(r);
                  ae[r] = 1'b0;
                  ng[r] = 1'b1;
                  aptr[d] = (r + 1) % 16;
               end
            end
            if (rem[d] <= 1) begin
               r = pick(me, RR ? mptr[d] : 0);
               if (r >= 0) begin
                  e.mv = 1'b1;
                  e.mr = 4'(r);
                  ng[r] = 1'b1;
                  mptr[d] = (r + 1) % 16;
               end
            end
         end
         e.done = (rem[d] == 1) && !f_i;
         rem[d] = f_i ? 0 : e.mv ? (d == 0 ? 2 : 1) : (rem[d] > 0 ? rem[d] - 1 : 0);
         e.busy = rem[d] >= 2;
         mg[d] = ng;
         if (d == 0) q0.push_back(e);
         else q1.push_back(e);
      end
      @(posedge clk);
      #1;
      if (q0.size() == 0) chk("sbq0_empty", 0, 1);
      else cmp(0, q0.pop_front());
      if (q1.size() == 0) chk("sbq1_empty", 0, 1);
      else cmp(1, q1.pop_front());
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_out_l2", {av0, ar0, mv0, mr0, dn0, bz0}, 0);
      chk("rst_out_l1", {av1, ar1, mv1, mr1, dn1, bz1}, 0);
      rst_n = 1'b1;
      model_reset();
      step(16'h0006, 16'h0000, 1'b0);
      chk("alu_pair_v", av0, 2'b11);
      chk("alu_pair_row", ar0, {4'd2, 4'd1});
      step(16'h0006, 16'h0000, 1'b0);
      chk("alu_gmask_v", av0, 2'b00);
      step(16'h4000, 16'h0000, 1'b0);
      step(16'h8001, 16'h0000, 1'b0);
      chk("alu_wrap_row", ar0, RR ? {4'd0, 4'd15} : {4'd15, 4'd0});
      repeat (2) step(16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(16'h0210, 16'h0210, 1'b0);
         if (i == 0) chk("mem_first_grant", {mv0, mr0}, {1'b1, 4'd4});
         d0v[i] = dn0;
         d1v[i] = dn1;
         b1v[i] = bz1;
      end
      chk("mem_done_l2", d0v, 6'b010100);
      chk("mem_done_l1", d1v, 6'b111110);
      chk("mem_busy_l1", b1v, 6'b000000);
      repeat (3) step(16'h0000, 16'h0000, 1'b0);
      step(16'h0010, 16'h0010, 1'b0);
      chk("flush_pre_busy", bz0, 1'b1);
      step(16'h0003, 16'h0000, 1'b1);
      chk("flush_grants", {av0, av1, mv0, mv1}, 0);
      chk("flush_done", {dn0, dn1}, 0);
      chk("flush_busy", bz0, 1'b0);
      step(16'h0000, 16'h0000, 1'b0);
      chk("flush_no_done", {dn0, dn1}, 0);
      repeat (200) step(16'($urandom), 16'($urandom), $urandom_range(0, 15) == 0);
      repeat (3) step(16'h0000, 16'h0000, 1'b0);
      step(16'h0010, 16'h0010, 1'b0);
      chk("rst_pre_grant", mv0, 1'b1);
      rdy = '0;
      ism = '0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_l2", {av0, ar0, mv0, mr0, dn0, bz0}, 0);
      chk("rst_async_l1", {av1, ar1, mv1, mr1, dn1, bz1}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (4) begin
         step(16'h0000, 16'h0000, 1'b0);
         chk("rst_no_done", {dn0, dn1}, 0);
      end
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/fu_issue_scheduler.md
# fu_issue_scheduler

Select/issue controller for the out-of-order back end. Each cycle it picks up to NUM_ALU_FUS ready ALU rows and one ready memory row from the reservation station, and grants them to the ALU and memory functional units. It also sequences the multi-cycle memory FU through a busy/done state machine. It sits between the reservation-station ready vectors and the FU issue registers, replacing the inline first-fit scan.

## Interface
- NUM_RS_ROWS, 16, reservation-station rows; power of two, ≥4
- NUM_ALU_FUS, 2, ALU grant ports (1 or 2)
- MEM_LATENCY, 2, cycles from memory grant to memory done; ≥1, ≤15
- clk_i  input  1  clock, all state on posedge
- rst_ni  input  1  reset, asynchronous, active-low
- flush_i  input  1  synchronous squash of in-flight scheduling state
- ready_vec_i  input  NUM_RS_ROWS  row used and all sources ready
- is_mem_vec_i  input  NUM_RS_ROWS  row targets memory FU (1) or ALU (0)
- alu_grant_valid_o  output  NUM_ALU_FUS  ALU port k granted this cycle
- alu_grant_row_o  output  NUM_ALU_FUS×$clog2(NUM_RS_ROWS)  row index per ALU port
- mem_grant_valid_o  output  1  memory FU granted this cycle
- mem_grant_row_o  output  $clog2(NUM_RS_ROWS)  granted memory row
- mem_done_o  output  1  one-cycle pulse: memory result valid
- mem_busy_o  output  1  memory FU cannot accept a grant at next edge

## Operation
- Eligible ALU row: ready_vec_i[r] & ~is_mem_vec_i[r] & ~gmask_q[r]. Eligible memory row: same with is_mem_vec_i[r]=1.
- gmask_q holds the rows granted at the previous edge. This prevents re-granting a row the RS has not yet dropped.
- ALU select: scan rows circularly starting at alu_ptr_q. The first eligible row goes to port 0, the second to port 1. Unused ports get valid=0 and row=0.
- alu_ptr_q ← (last ALU row granted + 1) mod NUM_RS_ROWS. It is unchanged when nothing is granted. Wrap from row NUM_RS_ROWS-1 to 0.
- Memory select: runs only when the FSM is MEM_IDLE or MEM_DONE. Scan circularly from mem_ptr_q. mem_ptr_q updates the same way as alu_ptr_q.
- Memory FSM states and transitions:
  - MEM_IDLE: on a grant, load cnt_q=MEM_LATENCY-1; go to MEM_DONE if cnt=0, else MEM_BUSY.
  - MEM_BUSY: decrement cnt_q each edge; when cnt_q==1, go to MEM_DONE.
  - MEM_DONE: assert mem_done_o. On a same-edge new grant, reload as from MEM_IDLE; else go to MEM_IDLE.
- mem_busy_o = (state==MEM_BUSY).
- flush_i:
  - Clears all grant outputs and gmask_q, and forces MEM_IDLE.
  - Pointers are kept.
  - Flush wins over any simultaneous select or mem_done.
- Reset (rst_ni=0):
  - All outputs 0, gmask_q=0, alu_ptr_q=mem_ptr_q=0, cnt_q=0, state MEM_IDLE.
  - Takes effect immediately and asynchronously, including mid memory op; no done pulse is emitted for the aborted op.

## Timing
- All outputs are registered. Inputs sampled at edge t produce grants valid during cycle t+1.
- Memory grant visible in cycle t+1 → mem_done_o high in cycle t+1+MEM_LATENCY, for exactly one cycle.
- Back-to-back memory ops: the grant may coincide with the mem_done_o cycle. Throughput is one op per MEM_LATENCY cycles.
- Empty eligibility: no grants, no pointer change. Full (all 16 ready): at most NUM_ALU_FUS+1 grants per cycle.

## Configuration
- FU_SCHED_ROUND_ROBIN_EN defined: circular scan from alu_ptr_q/mem_ptr_q as above.
- Not defined: fixed priority, lowest index first. Pointer registers are removed and the scan starts at row 0 every cycle.

## Structure
- Package fu_sched_pkg holds:
  - the enum fu_sched_mem_state_e {MEM_IDLE, MEM_BUSY, MEM_DONE};
  - localparams FU_ALU=0 and FU_MEM=1, shared with the dispatch/issue stage.
- One sub-module, rr_picker: a combinational find-first-set from a start index over a NUM_RS_ROWS vector, returning valid and index. It is instantiated once for memory and chained NUM_ALU_FUS times for ALU, masking earlier picks.

## Test plan
- Reset mid memory op (grant, then rst_ni low 1 cycle) → all outputs 0, state MEM_IDLE; no mem_done_o afterwards.
- ready_vec=0x0006, is_mem=0, ptr=0 → ALU port0 row1, port1 row2; next cycle no grant (gmask), alu_ptr=3.
- Round-robin wrap: ptr=15, ready rows {0,15} ALU → port0 row15, port1 row0, ptr=1. Without the macro → port0 row0, port1 row15.
- MEM_LATENCY=2, mem row 4 ready continuously with row 9 → grant row4 (cycle1), done cycle3 with grant row9 same cycle, done cycle5.
- MEM_LATENCY=1, same stimulus → done the cycle after each grant; mem_busy_o never high.
- flush_i asserted while MEM_BUSY with ALU rows ready → no grants, no mem_done_o that cycle, state MEM_IDLE next cycle.
